// File: rtl/vec_fifo_writer.sv
// vec_fifo_writer: serialises a packed NUM_ELEMS-element vector into a
// downstream FIFO one word per cycle, honouring fifo_full backpressure.
// Optional feature: define WRITER_CKSUM_EN to append a modulo-2^DATA_WIDTH
// checksum word after the last element.
// Latency: start sampled in IDLE at edge T, first word accepted at edge T+1.
module vec_fifo_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 4,
  parameter int IDX_WIDTH  = 3
) (
  input  logic                            clk_wr,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [NUM_ELEMS*DATA_WIDTH-1:0] vec_in,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_data,
  output logic                            busy,
  output logic                            done,
  output logic [15:0]                     stall_cnt
);

  // Index range is a power of two so any idx_reg value selects a defined slot.
  localparam int ELEM_SLOTS = 1 << IDX_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ELEMS - 1);

`ifdef WRITER_CKSUM_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    CKSUM = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t                          state_reg;
  logic [IDX_WIDTH-1:0]            idx_reg;
  logic [IDX_WIDTH-1:0]            idx_inc;
  logic [15:0]                     stall_cnt_reg;
  logic [15:0]                     stall_cnt_next;
  logic [DATA_WIDTH-1:0]           fifo_data_reg;
  logic [NUM_ELEMS*DATA_WIDTH-1:0] shadow_reg;
  logic [DATA_WIDTH-1:0]           shadow_elem [ELEM_SLOTS];
`ifdef WRITER_CKSUM_EN
  logic [DATA_WIDTH-1:0]           cksum_reg;
  logic [DATA_WIDTH-1:0]           cksum_next;
`endif

  // Unpack the shadow vector; slots past the last element read as zero.
  generate
    for (genvar gi = 0; gi < ELEM_SLOTS; gi++) begin : g_unpack
      if (gi < NUM_ELEMS) begin : g_elem
        assign shadow_elem[gi] = shadow_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_pad
        assign shadow_elem[gi] = '0;
      end
    end
  endgenerate

  assign idx_inc = idx_reg + 1'b1;

  // Saturating stall counter increment.
  assign stall_cnt_next = (stall_cnt_reg == 16'hFFFF) ? stall_cnt_reg
                                                       : stall_cnt_reg + 16'd1;

`ifdef WRITER_CKSUM_EN
  // Running sum including the element being accepted this cycle.
  assign cksum_next = cksum_reg + shadow_elem[idx_reg];
`endif

  // Write enable depends only on state; the FIFO decides acceptance via fifo_full.
  always_comb begin
    fifo_wr_en = 1'b0;
    if (state_reg == WRITE) begin
      fifo_wr_en = 1'b1;
    end
`ifdef WRITER_CKSUM_EN
    if (state_reg == CKSUM) begin
      fifo_wr_en = 1'b1;
    end
`endif
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign fifo_data = fifo_data_reg;
  assign stall_cnt = stall_cnt_reg;

  // Burst FSM: fifo_data_reg is preloaded with the next word so it is valid
  // in the same cycle the state asserts fifo_wr_en.
  always_ff @(posedge clk_wr) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      stall_cnt_reg <= '0;
      fifo_data_reg <= '0;
      shadow_reg    <= '0;
`ifdef WRITER_CKSUM_EN
      cksum_reg     <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            shadow_reg    <= vec_in;
            idx_reg       <= '0;
            stall_cnt_reg <= '0;
            fifo_data_reg <= vec_in[DATA_WIDTH-1:0];
`ifdef WRITER_CKSUM_EN
            cksum_reg     <= '0;
`endif
            state_reg     <= WRITE;
          end
        end

        WRITE: begin
          if (fifo_full) begin
            stall_cnt_reg <= stall_cnt_next;
          end else begin
`ifdef WRITER_CKSUM_EN
            cksum_reg <= cksum_next;
`endif
            if (idx_reg == LAST_IDX) begin
`ifdef WRITER_CKSUM_EN
              fifo_data_reg <= cksum_next;
              state_reg     <= CKSUM;
`else
              state_reg     <= DONE;
`endif
            end else begin
              idx_reg       <= idx_inc;
              fifo_data_reg <= shadow_elem[idx_inc];
            end
          end
        end

`ifdef WRITER_CKSUM_EN
        CKSUM: begin
          if (fifo_full) begin
            stall_cnt_reg <= stall_cnt_next;
          end else begin
            state_reg <= DONE;
          end
        end
`endif

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_fifo_writer.sv
// Testbench for vec_fifo_writer (DATA_WIDTH=8, NUM_ELEMS=4). Expected FIFO
// words are queued when a burst is launched and popped as words are accepted.
module tb_vec_fifo_writer;

  localparam int DW = 8;
  localparam int NE = 4;
  localparam int IW = 3;
`ifdef WRITER_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic           clk_wr = 1'b0;
  logic           rstn = 1'b0;
  logic           start = 1'b0;
  logic [NE*DW-1:0] vec_in = '0;
  logic           fifo_full = 1'b0;
  logic           fifo_wr_en;
  logic [DW-1:0]  fifo_data;
  logic           busy;
  logic           done;
  logic [15:0]    stall_cnt;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_word;

  vec_fifo_writer #(.DATA_WIDTH(DW), .NUM_ELEMS(NE), .IDX_WIDTH(IW)) dut (
    .clk_wr(clk_wr), .rstn(rstn), .start(start), .vec_in(vec_in),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk_wr = ~clk_wr;

  // Scoreboard: a word is accepted at the coming edge when wr_en=1 and full=0.
  always @(negedge clk_wr) begin
    if (rstn === 1'b1 && fifo_wr_en === 1'b1 && fifo_full === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write data=%h required=none", fifo_data);
      end else begin
        exp_word = exp_q.pop_front();
        if (fifo_data !== exp_word) begin
          failures++;
          $display("FAIL write_data got=%h required=%h", fifo_data, exp_word);
        end else begin
          $display("write data=%h ok", fifo_data);
        end
      end
    end
  end

  task automatic push_burst(input logic [NE*DW-1:0] v);
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < NE; k++) begin
      exp_q.push_back(v[k*DW +: DW]);
      s = s + v[k*DW +: DW];
    end
    if (CK == 1) exp_q.push_back(s);
  endtask

  // Returns #1 after edge T (the edge that samples start).
  task automatic fire(input logic [NE*DW-1:0] v, input bit do_push);
    @(posedge clk_wr);
    #1 start = 1'b1;
    vec_in = v;
    if (do_push) push_burst(v);
    @(posedge clk_wr);
    #1 start = 1'b0;
  endtask

  // Counts edges until done is seen, then checks the pulse is one cycle wide.
  task automatic wait_done(input int exp_n, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < 60) begin
      @(negedge clk_wr);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk_wr);
      n++;
    end
    checks++;
    if (!seen || n != exp_n) begin
      failures++;
      $display("FAIL %s_done_latency got=%0d seen=%0d required=%0d", name, n, seen, exp_n);
    end else begin
      $display("%s done after %0d edges ok", name, n);
    end
    @(negedge clk_wr);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse got done=%b busy=%b required done=0 busy=0", name, done, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes got=%0d_left required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk_wr);
    #1;
    checks++;
    if ({fifo_wr_en, busy, done} !== 3'b000 || stall_cnt !== 16'd0 || fifo_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_state got wr=%b busy=%b done=%b stall=%h data=%h required 0", fifo_wr_en, busy, done, stall_cnt, fifo_data);
    end
    rstn = 1'b1;
    @(negedge clk_wr);
    checks++;
    if ({fifo_wr_en, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_after got wr=%b busy=%b done=%b required 000", fifo_wr_en, busy, done);
    end
  endtask

  task automatic test_basic();
    fire(32'h04030201, 1'b1);
    wait_done(NE + CK, "basic");
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL basic_stall_cnt got=%0d required=0", stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    fire(32'h04030201, 1'b1);
    @(posedge clk_wr);
    #1 fifo_full = 1'b1;
    @(negedge clk_wr);
    checks++;
    if (fifo_data !== 8'h02 || fifo_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL stall_hold got data=%h wr=%b required data=02 wr=1", fifo_data, fifo_wr_en);
    end
    repeat (3) @(posedge clk_wr);
    #1 fifo_full = 1'b0;
    wait_done(3 + CK, "backpressure");
    checks++;
    if (stall_cnt !== 16'd3) begin
      failures++;
      $display("FAIL backpressure_stall_cnt got=%0d required=3", stall_cnt);
    end
  endtask

  task automatic test_overflow();
    fire(32'h0001FFFF, 1'b1);
    wait_done(NE + CK, "overflow");
  endtask

  task automatic test_start_busy();
    fire(32'h04030201, 1'b1);
    @(posedge clk_wr);
    #1 start = 1'b1;
    vec_in = 32'hAAAAAAAA;
    @(posedge clk_wr);
    #1 start = 1'b0;
    vec_in = '0;
    wait_done(2 + CK, "start_busy");
  endtask

  task automatic test_reset_mid();
    int done_seen;
    fire(32'h04030201, 1'b0);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    @(posedge clk_wr);
    @(posedge clk_wr);
    #1 rstn = 1'b0;
    @(posedge clk_wr);
    #1;
    checks++;
    if ({fifo_wr_en, busy, done} !== 3'b000 || stall_cnt !== 16'd0 || fifo_data !== 8'h00) begin
      failures++;
      $display("FAIL midreset_state got wr=%b busy=%b done=%b stall=%h data=%h required 0", fifo_wr_en, busy, done, stall_cnt, fifo_data);
    end
    rstn = 1'b1;
    done_seen = 0;
    repeat (8) begin
      @(negedge clk_wr);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_abandon got active_cycles=%0d left=%0d required 0 0", done_seen, exp_q.size());
      exp_q.delete();
    end
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_start_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_fifo_writer.md
VEC_FIFO_WRITER -- requirements
Module: vec_fifo_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element and FIFO word width in bits.
REQ-002 SHALL have parameter NUM_ELEMS, default 4, elements per vector burst; legal range 2..255.
REQ-003 SHALL have parameter IDX_WIDTH, default 3, element index width; must satisfy 2^IDX_WIDTH > NUM_ELEMS.
REQ-004 SHALL have port clk_wr, input, 1 bit, FIFO write-side clock; all logic on rising edge.
REQ-005 SHALL have port rstn, input, 1 bit, reset, synchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit, burst request, sampled only in IDLE.
REQ-007 SHALL have port vec_in, input, NUM_ELEMS*DATA_WIDTH bits, packed vector; element k = vec_in[k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port fifo_full, input, 1 bit, full flag from the downstream FIFO write side.
REQ-009 SHALL have port fifo_wr_en, output, 1 bit, FIFO write enable.
REQ-010 SHALL have port fifo_data, output, DATA_WIDTH bits, FIFO write data.
REQ-011 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit, one-cycle burst-complete pulse.
REQ-013 SHALL have port stall_cnt, output, 16 bits, cycles stalled by fifo_full in the current or most recent burst.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, CKSUM (macro-dependent), DONE.
REQ-015 SHALL, in IDLE with start=1 at edge T: latch vec_in into a shadow register, clear index and stall_cnt, and enter WRITE at T+1.
REQ-016 SHALL drive fifo_wr_en combinationally as 1 in WRITE or CKSUM and 0 otherwise, independent of fifo_full.
REQ-017 SHALL drive fifo_data from the shadow element[index] in WRITE, the checksum in CKSUM, and hold the last driven value elsewhere.
REQ-018 SHALL count a word as accepted at an edge only when fifo_wr_en=1 and fifo_full=0; on acceptance, index increments.
REQ-019 SHALL hold index and fifo_data unchanged while fifo_full=1, and increment stall_cnt each such cycle, saturating at 16'hFFFF.
REQ-020 SHALL write elements in order 0..NUM_ELEMS-1, one per cycle when unstalled; the first write is accepted at the end of cycle T+1.
REQ-021 SHALL, on acceptance of element NUM_ELEMS-1, go to CKSUM if WRITER_CKSUM_EN is defined, else go to DONE.
REQ-022 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-023 SHALL ignore start and vec_in changes outside IDLE; the shadow register is stable for the whole burst.
REQ-024 SHALL not accept start in DONE; a start held high is accepted on the first IDLE cycle after DONE.

Reset
REQ-025 SHALL, with rstn=0 at a clk_wr edge, force state IDLE, index 0, stall_cnt 0, fifo_data 0, shadow 0, and checksum 0.
REQ-026 SHALL, in reset and the cycle after, hold fifo_wr_en=0, busy=0, done=0.
REQ-027 SHALL, on reset mid-burst, abandon the burst with no further writes and no done pulse.

Configuration
REQ-028 SHALL, with macro WRITER_CKSUM_EN defined, accumulate the modulo-2^DATA_WIDTH sum of accepted elements.
REQ-029 SHALL, with WRITER_CKSUM_EN defined, write that sum as word NUM_ELEMS+1 in CKSUM with the same full/stall rules, then go to DONE.
REQ-030 SHALL, with WRITER_CKSUM_EN undefined, contain no CKSUM state or accumulator and write exactly NUM_ELEMS words per burst.

Verification (DATA_WIDTH=8, NUM_ELEMS=4)
REQ-031 SHALL cover basic burst: macro off, vec_in=32'h04030201, start at T, full=0 -> writes 01,02,03,04 at edges T+1..T+4, done at cycle T+5, stall_cnt=0.
REQ-032 SHALL cover backpressure: fifo_full=1 for 3 cycles starting T+2 -> fifo_data held at 02, stall_cnt=3, done at cycle T+8, order 01..04 preserved.
REQ-033 SHALL cover checksum with overflow: macro on, vec_in=32'h0001FFFF -> writes FF,FF,01,00,FF (5 words), done at cycle T+6.
REQ-034 SHALL cover start while busy: second start with vec_in=32'hAAAAAAAA at T+2 -> ignored, writes remain 01..04.
REQ-035 SHALL cover reset mid-burst: rstn=0 at T+3 -> no write after reset, busy=0, stall_cnt=0, no done pulse; a new start then behaves as REQ-031.
